idct2_odd16_acc: RTL and testbench

Sequential inverse DCT-II odd-part engine for the 32-point transform. It accepts the 16 odd-index coefficients Y[1], Y[3], …, Y[31] one per handshake beat. It multiplies each coefficient by its column of the 32-point odd matrix using multiplierless shift-add constants, and accumulates into the 16 odd-part sums O[0..15]. It sits in the inverse transform path, feeding the even/odd butterfly, and consumes the same 15 coefficient magnitudes that the forward path produces.

---
 rtl/idct2_odd16_acc_if.sv | 23 ++
 rtl/idct2_odd16_acc.sv | 124 ++++++++++++
 tb/tb_idct2_odd16_acc.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idct2_odd16_acc_if.sv
// Handshake bundle for the 32-point IDCT odd-part accumulator.
// Coefficient beats flow in, and the packed O[0..15] vector flows out.
interface idct2_odd16_acc_if #(
   parameter int IN_W  = 16,
   parameter int ACC_W = 27
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [IN_W-1:0]  in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [16*ACC_W-1:0]     out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/idct2_odd16_acc.sv
// Sequential odd-part engine of the 32-point inverse DCT-II: one odd coefficient per beat,
// multiplied by its matrix column with shift-add constants and accumulated into O[0..15].
module idct2_odd16_acc #(
   parameter int IN_W  = 16,
   parameter int ACC_W = 27
) (
   input logic                clk,
   input logic                rst_n,
   idct2_odd16_acc_if.slave   bus
);

   typedef enum logic {ACCUM, DONE} state_t;

   state_t                   state, state_nx;
   logic [3:0]               cnt, cnt_nx;
   logic                     accept;
   logic                     in_ready_c, out_valid_c;
   logic signed [ACC_W-1:0]  x;
   logic signed [ACC_W-1:0]  mag [16];
   logic signed [ACC_W-1:0]  acc [16];
   logic signed [ACC_W-1:0]  upd [16];
   logic [16*ACC_W-1:0]      packed_out;

   // Returns {negate, table index} for beat m and output n, using p = (2m+1)(2n+1) mod 128.
   function automatic logic [4:0] entry(input int m, input int n);
      int p;
      p = 0;
      for (int k = 0; k < n + n + 1; k++) p = (p + m + m + 1) % 128;
      if (p < 32)      return {1'b0, 4'((p - 1) / 2)};
      else if (p < 64) return {1'b1, 4'((63 - p) / 2)};
      else if (p < 96) return {1'b1, 4'((p - 65) / 2)};
      else             return {1'b0, 4'((127 - p) / 2)};
   endfunction

   assign x = {{(ACC_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};

   // The 15 distinct magnitudes, built once per beat; T[0] and T[1] are both 90.
   assign mag[0]  = (x <<< 6) + (x <<< 4) + (x <<< 3) + (x <<< 1);
   assign mag[1]  = mag[0];
   assign mag[2]  = (x <<< 6) + (x <<< 4) + (x <<< 3);
   assign mag[3]  = (x <<< 6) + (x <<< 4) + (x <<< 2) + x;
   assign mag[4]  = (x <<< 6) + (x <<< 4) + (x <<< 1);
   assign mag[5]  = (x <<< 6) + (x <<< 3) + (x <<< 2) + (x <<< 1);
   assign mag[6]  = (x <<< 6) + (x <<< 3) + x;
   assign mag[7]  = (x <<< 6) + (x <<< 1) + x;
   assign mag[8]  = (x <<< 6) - (x <<< 1) - x;
   assign mag[9]  = (x <<< 6) - (x <<< 3) - (x <<< 1);
   assign mag[10] = (x <<< 5) + (x <<< 4) - (x <<< 1);
   assign mag[11] = (x <<< 5) + (x <<< 2) + (x <<< 1);
   assign mag[12] = (x <<< 5) - x;
   assign mag[13] = (x <<< 4) + (x <<< 2) + (x <<< 1);
   assign mag[14] = (x <<< 3) + (x <<< 2) + x;
   assign mag[15] = (x <<< 2);

   // Each output selects its (sign, magnitude) for the current beat; beat 0 loads instead of adding.
   for (genvar n = 0; n < 16; n++) begin : g_col
      logic [4:0]               sel [16];
      logic [4:0]               e;
      logic signed [ACC_W-1:0]  base;
      logic signed [ACC_W-1:0]  prodv;

      for (genvar m = 0; m < 16; m++) begin : g_row
         localparam logic [4:0] E = entry(m, n);
         assign sel[m] = E;
      end

      assign e      = sel[cnt];
      assign base   = (cnt == 4'd0) ? '0 : acc[n];
      assign prodv  = mag[e[3:0]];
      assign upd[n] = e[4] ? (base - prodv) : (base + prodv);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACCUM;
         cnt   <= 4'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < 16; n++) acc[n] <= '0;
      end else if (accept) begin
         for (int n = 0; n < 16; n++) acc[n] <= upd[n];
      end
   end

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      accept      = 1'b0;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state)
         ACCUM: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               accept = 1'b1;
               cnt_nx = cnt + 4'd1;
               if (cnt == 4'd15) state_nx = DONE;
            end
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_nx = ACCUM;
         end
         default: state_nx = ACCUM;
      endcase
   end

   // Shifting each sum in from the top leaves O[0] in the lowest slice.
   always_comb begin
      packed_out = '0;
      for (int n = 0; n < 16; n++) packed_out = {acc[n], packed_out[16*ACC_W-1:ACC_W]};
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_data  = packed_out;

endmodule

// File: tb/tb_idct2_odd16_acc.sv
// Directed bench for idct2_odd16_acc: impulse columns, extremes, backpressure,
// mid-block reset and back-to-back throughput against a behavioural matrix model.
module tb_idct2_odd16_acc;

   localparam int IN_W  = 16;
   localparam int ACC_W = 27;
   localparam int OW    = 16 * ACC_W;
   localparam int TT [16] = '{90, 90, 88, 85, 82, 78, 73, 67, 61, 54, 46, 38, 31, 22, 13, 4};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   idct2_odd16_acc_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus ();

   idct2_odd16_acc #(.IN_W(IN_W), .ACC_W(ACC_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   logic signed [IN_W-1:0] blk [16];
   logic [OW-1:0]          expv;
   logic signed [ACC_W-1:0] o;

   function automatic logic [OW-1:0] model_out();
      logic [OW-1:0] r;
      longint s;
      int p, c;
      r = '0;
      for (int n = 0; n < 16; n++) begin
         s = 0;
         for (int m = 0; m < 16; m++) begin
            p = ((2*m + 1) * (2*n + 1)) % 128;
            if (p < 32)      c = TT[(p - 1) / 2];
            else if (p < 64) c = -TT[(63 - p) / 2];
            else if (p < 96) c = -TT[(p - 65) / 2];
            else             c = TT[(127 - p) / 2];
            s += longint'(c) * longint'(blk[m]);
         end
         r[n*ACC_W +: ACC_W] = s[ACC_W-1:0];
      end
      return r;
   endfunction

   function automatic logic [OW-1:0] impulse_col();
      logic [OW-1:0] r;
      for (int n = 0; n < 16; n++) r[n*ACC_W +: ACC_W] = ACC_W'(TT[n]);
      return r;
   endfunction

   // Drives nbeats beats starting from a negedge; returns on the negedge after the last accept.
   task automatic send_beats(input int nbeats, input bit gaps);
      int guard;
      for (int m = 0; m < nbeats; m++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         guard = 0;
         while (bus.in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 100) begin
            vectors++; miscompares++;
            $display("[TB] FAIL in_ready_timeout beat=%0d actual in_ready=%b required 1", m, bus.in_ready);
         end
         bus.in_valid = 1'b1;
         bus.in_data  = blk[m];
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++; $display("[TB] FAIL reset_in_ready actual=%b required=1", bus.in_ready);
      end
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++; $display("[TB] FAIL reset_out_valid actual=%b required=0", bus.out_valid);
      end
      vectors++;
      if (bus.out_data !== '0) begin
         miscompares++; $display("[TB] FAIL reset_out_data actual=%h required=0", bus.out_data);
      end
   endtask

   task automatic test_impulse_first();
      for (int m = 0; m < 16; m++) blk[m] = '0;
      blk[0] = 16'sd1;
      bus.out_ready = 1'b1;
      send_beats(16, 1'b0);
      vectors++;
      if (bus.out_valid !== 1'b1) begin
         miscompares++; $display("[TB] FAIL imp1_out_valid actual=%b required=1", bus.out_valid);
      end
      vectors++;
      if (bus.out_data !== impulse_col()) begin
         miscompares++; $display("[TB] FAIL imp1_data actual=%h required=%h", bus.out_data, impulse_col());
      end
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL imp1_one_cycle actual valid=%b ready=%b required valid=0 ready=1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_impulse_last();
      for (int m = 0; m < 16; m++) blk[m] = '0;
      blk[15] = 16'sd1;
      bus.out_ready = 1'b1;
      send_beats(16, 1'b0);
      o = bus.out_data[0 +: ACC_W];
      vectors++;
      if (int'(o) !== 4) begin
         miscompares++; $display("[TB] FAIL imp31_o0 actual=%0d required=4", o);
      end
      o = bus.out_data[ACC_W +: ACC_W];
      vectors++;
      if (int'(o) !== -13) begin
         miscompares++; $display("[TB] FAIL imp31_o1 actual=%0d required=-13", o);
      end
      o = bus.out_data[2*ACC_W +: ACC_W];
      vectors++;
      if (int'(o) !== 22) begin
         miscompares++; $display("[TB] FAIL imp31_o2 actual=%0d required=22", o);
      end
      o = bus.out_data[15*ACC_W +: ACC_W];
      vectors++;
      if (int'(o) !== -90) begin
         miscompares++; $display("[TB] FAIL imp31_o15 actual=%0d required=-90", o);
      end
      expv = model_out();
      vectors++;
      if (bus.out_data !== expv) begin
         miscompares++; $display("[TB] FAIL imp31_data actual=%h required=%h", bus.out_data, expv);
      end
      @(negedge clk);
   endtask

   task automatic test_full_negative();
      for (int m = 0; m < 16; m++) blk[m] = 16'sh8000;
      bus.out_ready = 1'b1;
      send_beats(16, 1'b1);
      o = bus.out_data[0 +: ACC_W];
      vectors++;
      if (int'(o) !== -30212096) begin
         miscompares++; $display("[TB] FAIL neg_o0 actual=%0d required=-30212096", o);
      end
      expv = model_out();
      vectors++;
      if (bus.out_data !== expv) begin
         miscompares++; $display("[TB] FAIL neg_data actual=%h required=%h", bus.out_data, expv);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      for (int m = 0; m < 16; m++) blk[m] = 16'($urandom);
      bus.out_ready = 1'b0;
      send_beats(16, 1'b1);
      expv = model_out();
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 16'($urandom);
         vectors++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== expv) begin
            miscompares++;
            $display("[TB] FAIL stall_%0d actual valid=%b ready=%b data=%h required valid=1 ready=0 data=%h",
                     i, bus.out_valid, bus.in_ready, bus.out_data, expv);
         end
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL stall_release actual valid=%b ready=%b required valid=0 ready=1", bus.out_valid, bus.in_ready);
      end
      for (int m = 0; m < 16; m++) blk[m] = 16'($urandom);
      send_beats(16, 1'b0);
      expv = model_out();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== expv) begin
         miscompares++;
         $display("[TB] FAIL after_stall actual valid=%b data=%h required valid=1 data=%h", bus.out_valid, bus.out_data, expv);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      for (int m = 0; m < 16; m++) blk[m] = 16'($urandom) | 16'h0001;
      bus.out_ready = 1'b1;
      send_beats(8, 1'b0);
      rst_n = 1'b0;
      #1;
      vectors++;
      if (bus.out_data !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL midreset actual data=%h valid=%b ready=%b required data=0 valid=0 ready=1",
                  bus.out_data, bus.out_valid, bus.in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int m = 0; m < 16; m++) blk[m] = '0;
      blk[0] = 16'sd1;
      send_beats(16, 1'b0);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== impulse_col()) begin
         miscompares++;
         $display("[TB] FAIL midreset_after actual valid=%b data=%h required valid=1 data=%h",
                  bus.out_valid, bus.out_data, impulse_col());
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int last_cyc;
      last_cyc = -1;
      bus.out_ready = 1'b1;
      for (int b = 0; b < 100; b++) begin
         for (int m = 0; m < 16; m++) blk[m] = 16'($urandom);
         expv = model_out();
         send_beats(16, 1'b0);
         vectors++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== expv) begin
            miscompares++;
            $display("[TB] FAIL b2b_%0d actual valid=%b data=%h required valid=1 data=%h",
                     b, bus.out_valid, bus.out_data, expv);
         end
         if (b > 0) begin
            vectors++;
            if (cyc - last_cyc !== 17) begin
               miscompares++;
               $display("[TB] FAIL b2b_period_%0d actual=%0d required=17", b, cyc - last_cyc);
            end
         end
         last_cyc = cyc;
         @(negedge clk);
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_impulse_first();
      test_impulse_last();
      test_full_negative();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule
